// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-bus bundle between the MEM-stage access unit and data memory.
// The master drives the request side; the slave returns ack and read data.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: alignment check, lane steering,
// variable-latency bus handshake with timeout, and load extension.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [1:0]        exc,
  mem_access_unit_if.master bus
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [CW-1:0]     cnt;
  logic              ld_q, sgn_q;
  logic [1:0]        sz_q;   // 0 byte, 1 half, 2 word
  logic [1:0]        off_q;

  logic is_load, is_store, is_word, is_half, access, misalign, timeout_hit;
  logic [1:0]  sz_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, lane, ld_data;

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;

  always_comb begin
    is_load  = (mem_op == 4'd0) || (mem_op == 4'd2) || (mem_op == 4'd3) ||
               (mem_op == 4'd4) || (mem_op == 4'd5);
    is_store = (mem_op == 4'd1) || (mem_op == 4'd6) || (mem_op == 4'd7);
    is_word  = (mem_op == 4'd0) || (mem_op == 4'd1);
    is_half  = (mem_op == 4'd2) || (mem_op == 4'd4) || (mem_op == 4'd6);
    sz_d     = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    access   = valid_in && !mem_op[3];
    misalign = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    // Loads always fetch the whole word; lane selection happens on return.
    be_d    = 4'hF;
    wdata_d = wdata;
    if (is_store && is_half) begin
      be_d    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {wdata[15:0], wdata[15:0]};
    end else if (is_store && !is_word) begin
      be_d    = 4'b0001 << addr[1:0];
      wdata_d = {4{wdata[7:0]}};
    end
  end

  always_comb begin
    lane    = bus.rdata >> {off_q, 3'b000};
    ld_data = lane;
    case (sz_q)
      2'd1:    ld_data = {{16{sgn_q & lane[15]}}, lane[15:0]};
      2'd0:    ld_data = {{24{sgn_q & lane[7]}}, lane[7:0]};
      default: ld_data = lane;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        stall = access;
        if (access) state_nxt = misalign ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.ack || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      ld_q    <= 1'b0;
      sgn_q   <= 1'b0;
      sz_q    <= '0;
      off_q   <= '0;
      rdata   <= '0;
      exc     <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          if (misalign) begin
            exc <= is_load ? 2'd1 : 2'd2;
          end else begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt     <= '0;
            ld_q    <= is_load;
            sgn_q   <= (mem_op == 4'd2) || (mem_op == 4'd3);
            sz_q    <= sz_d;
            off_q   <= addr[1:0];
          end
        end
        WAIT: begin
          // A same-cycle ack beats the timeout.
          if (bus.ack) begin
            req_q <= 1'b0;
            if (ld_q) rdata <= ld_data;
          end else if (timeout_hit) begin
            req_q <= 1'b0;
            exc   <= 2'd3;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    exc <= 2'd0;
        default: exc <= 2'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/idle corner cases,
// and randomized operations checked against an arithmetic reference model.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        stall, done;
  logic [31:0] rdata;
  logic [1:0]  exc;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .exc(exc), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  exc;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic        we;
    int          stalls;
    int          reqs;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, wd, rw;
    int          ackw;
    exp_t        e;
  } vec_t;

  int checks = 0, failures = 0;

  // observations from the last run_op
  int          o_stalls, o_reqs, o_stab;
  logic        o_done, o_we;
  logic [1:0]  o_exc;
  logic [31:0] o_rdata, o_baddr, o_bwd;
  logic [3:0]  o_be;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, wd, rw,
                                 input int ackw, input logic [31:0] prev);
    exp_t m; int sz, off; bit ld, sgn; logic [63:0] v, mask;
    off = int'(a[1:0]);
    sz  = (op == 0 || op == 1) ? 4 : ((op == 2 || op == 4 || op == 6) ? 2 : 1);
    ld  = (op == 0 || op == 2 || op == 3 || op == 4 || op == 5);
    sgn = (op == 2 || op == 3);
    m.exc = 0; m.rdata = prev; m.be = 0; m.bwd = 0; m.we = !ld; m.stalls = 1; m.reqs = 0;
    if (off % sz != 0) begin
      m.exc = ld ? 2'd1 : 2'd2;
    end else begin
      m.be  = ld ? 4'hF : 4'(((1 << sz) - 1) << off);
      m.bwd = (sz == 4) ? wd : ((sz == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}});
      if (ackw < TO) begin
        m.stalls = 2 + ackw;
        m.reqs   = ackw + 1;
        if (ld) begin
          mask = (64'd1 << (8 * sz)) - 64'd1;
          v    = ({32'd0, rw} >> (8 * off)) & mask;
          if (sgn && v[8 * sz - 1]) v = v | ~mask;
          m.rdata = v[31:0];
        end
      end else begin
        m.exc = 2'd3; m.stalls = 1 + TO; m.reqs = TO;
      end
    end
    return m;
  endfunction

  // Issue one operation and act as the bus slave; ackw = index of the WAIT cycle
  // carrying the ack (large value = never ack).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, wd, rw, input int ackw);
    o_stalls = 0; o_reqs = 0; o_stab = 0; o_done = 0; o_exc = 0; o_rdata = 0;
    o_be = 0; o_we = 0; o_baddr = 0; o_bwd = 0;
    @(negedge clk);
    valid_in = 1; mem_op = op; addr = a; wdata = wd; bus.ack = 0;
    for (int c = 0; c < 40 && !o_done; c++) begin
      #1;
      if (stall) o_stalls++;
      if (bus.req) begin
        if (o_reqs == 0) begin
          o_be = bus.be; o_we = bus.we; o_baddr = bus.addr; o_bwd = bus.wdata;
        end else if ({bus.be, bus.we, bus.addr, bus.wdata} !== {o_be, o_we, o_baddr, o_bwd}) begin
          o_stab++;
        end
        bus.ack   = (o_reqs == ackw);
        bus.rdata = bus.ack ? rw : $urandom;
        o_reqs++;
      end else begin
        bus.ack = 0; bus.rdata = $urandom;
      end
      if (done) begin
        o_done = 1; o_exc = exc; o_rdata = rdata;
        valid_in = 0; mem_op = 4'hF;
      end
      @(negedge clk);
    end
    bus.ack = 0; valid_in = 0; mem_op = 4'hF;
  endtask

  task automatic compare(input string t, input logic [31:0] a, input exp_t e);
    chk({t, ".done"},   32'(o_done),   32'd1);
    chk({t, ".exc"},    32'(o_exc),    32'(e.exc));
    chk({t, ".rdata"},  o_rdata,       e.rdata);
    chk({t, ".stalls"}, 32'(o_stalls), 32'(e.stalls));
    chk({t, ".reqs"},   32'(o_reqs),   32'(e.reqs));
    if (e.reqs > 0) begin
      chk({t, ".be"},     32'(o_be),   32'(e.be));
      chk({t, ".we"},     32'(o_we),   32'(e.we));
      chk({t, ".baddr"},  o_baddr,     a & 32'hFFFF_FFFC);
      chk({t, ".stable"}, 32'(o_stab), 32'd0);
      if (e.we) chk({t, ".bwdata"}, o_bwd, e.bwd);
    end
  endtask

  vec_t tbl[13];
  logic [31:0] model_rdata;

  initial begin
    reset = 1; valid_in = 0; mem_op = 4'hF; addr = 0; wdata = 0;
    bus.ack = 0; bus.rdata = 0;

    //              op  addr          wdata         bus_rdata     ackw   exc rdata        be     bwd           we stalls reqs
    tbl[0]  = '{4'd0, 32'h1000, 32'h0,        32'h8899AABB, 0,   '{2'd0, 32'h8899AABB, 4'hF, 32'h0,        1'b0, 2, 1}};
    tbl[1]  = '{4'd3, 32'h1003, 32'h0,        32'h80112233, 0,   '{2'd0, 32'hFFFFFF80, 4'hF, 32'h0,        1'b0, 2, 1}};
    tbl[2]  = '{4'd5, 32'h1003, 32'h0,        32'h80112233, 1,   '{2'd0, 32'h00000080, 4'hF, 32'h0,        1'b0, 3, 2}};
    tbl[3]  = '{4'd6, 32'h2002, 32'h1234ABCD, 32'h0,        3,   '{2'd0, 32'h00000080, 4'hC, 32'hABCDABCD, 1'b1, 5, 4}};
    tbl[4]  = '{4'd2, 32'h3001, 32'h0,        32'h0,        0,   '{2'd1, 32'h00000080, 4'h0, 32'h0,        1'b0, 1, 0}};
    tbl[5]  = '{4'd1, 32'h3002, 32'h55,       32'h0,        0,   '{2'd2, 32'h00000080, 4'h0, 32'h0,        1'b1, 1, 0}};
    tbl[6]  = '{4'd0, 32'h5000, 32'h0,        32'h12345678, 100, '{2'd3, 32'h00000080, 4'hF, 32'h0,        1'b0, 5, 4}};
    tbl[7]  = '{4'd0, 32'h5004, 32'h0,        32'hDEADBEEF, 3,   '{2'd0, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 5, 4}};
    tbl[8]  = '{4'd7, 32'h6001, 32'h000000A5, 32'h0,        0,   '{2'd0, 32'hDEADBEEF, 4'h2, 32'hA5A5A5A5, 1'b1, 2, 1}};
    tbl[9]  = '{4'd4, 32'h7002, 32'h0,        32'hF00D1234, 0,   '{2'd0, 32'h0000F00D, 4'hF, 32'h0,        1'b0, 2, 1}};
    tbl[10] = '{4'd2, 32'h7002, 32'h0,        32'hF00D1234, 2,   '{2'd0, 32'hFFFFF00D, 4'hF, 32'h0,        1'b0, 4, 3}};
    tbl[11] = '{4'd1, 32'h8000, 32'hCAFEF00D, 32'h0,        0,   '{2'd0, 32'hFFFFF00D, 4'hF, 32'hCAFEF00D, 1'b1, 2, 1}};
    tbl[12] = '{4'd3, 32'h8000, 32'h0,        32'h0000007F, 0,   '{2'd0, 32'h0000007F, 4'hF, 32'h0,        1'b0, 2, 1}};

    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 32'(stall),   32'd0);
    chk("rst.done",  32'(done),    32'd0);
    chk("rst.req",   32'(bus.req), 32'd0);
    chk("rst.exc",   32'(exc),     32'd0);
    chk("rst.rdata", rdata,        32'd0);
    reset = 0;

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].rw, tbl[i].ackw);
      compare($sformatf("vec%0d", i), tbl[i].a, tbl[i].e);
    end

    // Non-memory ops and stray acks in IDLE do nothing.
    @(negedge clk);
    valid_in = 1; mem_op = 4'd9; addr = 32'h9000;
    bus.ack = 1; bus.rdata = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("nop.stall", 32'(stall),   32'd0);
      chk("nop.req",   32'(bus.req), 32'd0);
      chk("nop.done",  32'(done),    32'd0);
      @(negedge clk);
    end
    bus.ack = 0; valid_in = 0; mem_op = 4'hF;
    chk("nop.rdata", rdata, 32'h0000007F);

    // Reset in the middle of a store's WAIT phase.
    @(negedge clk);
    valid_in = 1; mem_op = 4'd1; addr = 32'h4000; wdata = 32'h77777777; bus.ack = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rstw.req_before", 32'(bus.req), 32'd1);
    valid_in = 0; mem_op = 4'hF;
    #1 reset = 1;
    #1;
    chk("rstw.req",   32'(bus.req), 32'd0);
    chk("rstw.stall", 32'(stall),   32'd0);
    chk("rstw.rdata", rdata,        32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rstw.nodone", 32'(done), 32'd0);
    end
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rstw.nodone_after", 32'(done), 32'd0);
    end
    run_op(4'd5, 32'h4001, 32'h0, 32'h0000FF00, 0);
    compare("rstw.lbu", 32'h4001, '{2'd0, 32'h000000FF, 4'hF, 32'h0, 1'b0, 2, 1});

    // Randomized traffic against the reference model.
    model_rdata = 32'h000000FF;
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op; logic [31:0] a, wd, rw; int aw; exp_t e;
      op = 4'($urandom_range(0, 7));
      a  = $urandom; wd = $urandom; rw = $urandom;
      aw = $urandom_range(0, 5);
      e  = model(op, a, wd, rw, aw, model_rdata);
      run_op(op, a, wd, rw, aw);
      compare($sformatf("rnd%0d", i), a, e);
      model_rdata = e.rdata;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller for the pipelined MIPS core.
- Takes the 4-bit memory-operation code produced by the MEM-stage opcode decoder, plus the address and store data.
- Drives a variable-latency request/acknowledge data bus, with byte enables and lane-aligned write data.
- Returns sign- or zero-extended load data, stalls the pipeline while the bus is busy, and reports address and bus-timeout exceptions.

Parameters:
- ADDR_W, 32, byte-address width on both the core side and the bus side.
- TIMEOUT, 255, maximum number of WAIT cycles before a bus timeout is declared; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  MEM-stage instruction valid.
- mem_op  in  4  operation code: 0 lw, 1 sw, 2 lh, 3 lb, 4 lhu, 5 lbu, 6 sh, 7 sb, 8..15 no memory access.
- addr  in  ADDR_W  effective byte address.
- wdata  in  32  store data, taken from the rt register.
- stall  out  1  freeze the pipeline at and before the MEM stage.
- done  out  1  one-cycle pulse: result or exception is valid.
- rdata  out  32  extended load result, held until the next done pulse.
- exc  out  2  0 none, 1 AdEL (load misaligned), 2 AdES (store misaligned), 3 bus timeout; valid when done=1.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address, addr with [1:0] forced to 0.
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian).
- bus_wdata  out  32  lane-aligned write data.
- bus_ack  in  1  bus completion, single-cycle pulse.
- bus_rdata  in  32  read word, valid when bus_ack=1.

Behaviour:
- States: IDLE, WAIT, DONE. Reset (asynchronous, effective immediately) forces IDLE and zeroes all outputs and registers, including bus_req. Reset during WAIT abandons the transaction with no done pulse.
- Access condition (in IDLE): valid_in=1 and mem_op<8.
  - Misaligned address: word ops need addr[1:0]==0; half ops need addr[0]==0.
    - Next state DONE, with exc=1 for loads or exc=2 for stores.
    - No bus request is made.
  - Aligned address:
    - Register bus_addr, bus_we, bus_be and bus_wdata; set bus_req=1.
    - Next state WAIT.
  - Otherwise: remain in IDLE, stall=0.
- Byte enables: sw = 1111. sh = 1100 if addr[1]=1, else 0011. sb = 0001 shifted left by addr[1:0]. Loads = 1111.
- Write data: sw = wdata. sh = {wdata[15:0], wdata[15:0]}. sb = wdata[7:0] replicated into all four lanes.
- WAIT:
  - bus_req and all bus outputs stay stable until bus_ack=1.
  - On bus_ack:
    - Drop bus_req.
    - For loads, capture extracted data into rdata: half = lane addr[1], byte = lane addr[1:0].
    - lh and lb sign-extend; lhu and lbu zero-extend; lw passes through.
    - Stores leave rdata unchanged.
    - Next state DONE.
  - Timeout counter:
    - Cleared on entry to WAIT; increments each WAIT cycle without bus_ack.
    - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack: next state DONE, exc=3, drop bus_req.
    - bus_ack in the same cycle as the timeout wins (normal completion).
- DONE:
  - done=1 for exactly one cycle; exc holds its code; stall=0.
  - Next state IDLE unconditionally; a new operation is never accepted in DONE.
- stall is combinational: 1 when (IDLE and access condition) or in WAIT; 0 otherwise.
- exc returns to 0 on leaving DONE. rdata holds its value.
- bus_ack while in IDLE or DONE is ignored.
- Latency: zero-wait-state bus (ack in the first WAIT cycle) gives done 2 cycles after acceptance, with stall high for 2 cycles. Each extra bus wait cycle adds 1.

Test Plan:
- lw, addr=0x1000, bus_rdata=0x8899AABB, ack in the first WAIT cycle -> bus_be=1111, bus_we=0, stall high 2 cycles, done pulse, rdata=0x8899AABB, exc=0.
- lb, addr=0x1003, bus_rdata=0x80112233; then lbu at the same address -> bus_addr=0x1000, rdata=0xFFFFFF80, then 0x00000080.
- sh, addr=0x2002, wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, bus outputs stable across 3 wait cycles until ack.
- lh at addr=0x3001, and sw at addr=0x3002 -> no bus_req; done with exc=1 and exc=2 respectively; stall high exactly 1 cycle each.
- TIMEOUT=4, lw with bus_ack never asserted -> bus_req high 4 cycles then drops, done with exc=3. Repeat with ack on the 4th WAIT cycle -> exc=0.
- Assert reset during WAIT of an sw -> bus_req=0 immediately, no done pulse. After reset release, an lbu at addr=0x4001 with bus_rdata=0x0000FF00 completes normally with rdata=0x000000FF.
